// File: rtl/chip8_xfer_engine.sv
`default_nettype none
// ============================================================================
// chip8_xfer_engine : Fx55 / Fx65 / Fx33 register<->memory transfer sequencer
// Revision 1.0
// ============================================================================
module chip8_xfer_engine #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int MEM_LATENCY    = 1,
  parameter bit INC_I          = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [1:0]                mode_i,
  input  logic [REG_ADDR_WIDTH-1:0] x_i,
  input  logic [ADDR_WIDTH-1:0]     i_in_i,
  output logic [REG_ADDR_WIDTH-1:0] reg_raddr_o,
  input  logic [DATA_WIDTH-1:0]     reg_q_i,
  output logic                      reg_we_o,
  output logic [REG_ADDR_WIDTH-1:0] reg_waddr_o,
  output logic [DATA_WIDTH-1:0]     reg_d_o,
  output logic [ADDR_WIDTH-1:0]     mem_raddr_o,
  input  logic [DATA_WIDTH-1:0]     mem_q_i,
  output logic                      mem_we_o,
  output logic [ADDR_WIDTH-1:0]     mem_waddr_o,
  output logic [DATA_WIDTH-1:0]     mem_d_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      i_we_o,
  output logic [ADDR_WIDTH-1:0]     i_out_o
);

  localparam int         CW           = REG_ADDR_WIDTH + 1;
  localparam logic [1:0] c_MODE_STORE = 2'b00;
  localparam logic [1:0] c_MODE_LOAD  = 2'b01;
  localparam logic [1:0] c_MODE_BCD   = 2'b10;
  localparam logic [1:0] c_MODE_ILL   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_REG   = 3'd1,
    S_RD_MEM   = 3'd2,
    S_STREAM   = 3'd3,
    S_BCD_CONV = 3'd4,
    S_BCD_WR   = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t                    state_q, state_d;
  logic [1:0]                mode_q, mode_d;
  logic [ADDR_WIDTH-1:0]     base_q, base_d;
  logic [REG_ADDR_WIDTH-1:0] last_q, last_d;
  logic [REG_ADDR_WIDTH-1:0] rcnt_q, rcnt_d;
  logic [CW-1:0]             wcnt_q, wcnt_d;
  logic                      iss_q, iss_d;
  logic [MEM_LATENCY-1:0]    vpipe_q, vpipe_d;
  logic [DATA_WIDTH-1:0]     bin_q, bin_d;
  logic [11:0]               bcd_q, bcd_d;
  logic [2:0]                bcnt_q, bcnt_d;
  logic [REG_ADDR_WIDTH-1:0] reg_raddr_q, reg_raddr_d;
  logic                      reg_we_q, reg_we_d;
  logic [REG_ADDR_WIDTH-1:0] reg_waddr_q, reg_waddr_d;
  logic [DATA_WIDTH-1:0]     reg_d_q, reg_d_d;
  logic [ADDR_WIDTH-1:0]     mem_raddr_q, mem_raddr_d;
  logic                      mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]     mem_waddr_q, mem_waddr_d;
  logic [DATA_WIDTH-1:0]     mem_d_q, mem_d_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      i_we_q, i_we_d;
  logic [ADDR_WIDTH-1:0]     i_out_q, i_out_d;

  logic                      w_dv;
  logic [CW-1:0]             w_total;
  logic [REG_ADDR_WIDTH-1:0] w_rnext;
  logic [11:0]               w_bcd_adj;
  logic [11:0]               w_bcd_n;
  logic [DATA_WIDTH-1:0]     w_bin_n;

  // Read data lands one cycle after a V-RAM address, MEM_LATENCY after a memory address
  assign w_dv    = (mode_q == c_MODE_STORE) ? vpipe_q[0] : vpipe_q[MEM_LATENCY-1];
  assign w_total = CW'(last_q) + CW'(1);
  assign w_rnext = rcnt_q + REG_ADDR_WIDTH'(1);

  always_comb begin
    w_bcd_adj = bcd_q;
    for (int d = 0; d < 3; d++) begin
      if (w_bcd_adj[4*d +: 4] >= 4'd5) begin
        w_bcd_adj[4*d +: 4] = w_bcd_adj[4*d +: 4] + 4'd3;
      end
    end
    {w_bcd_n, w_bin_n} = {w_bcd_adj, bin_q} << 1;
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    base_d      = base_q;
    last_d      = last_q;
    rcnt_d      = rcnt_q;
    wcnt_d      = wcnt_q;
    iss_d       = iss_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    bcnt_d      = bcnt_q;
    reg_raddr_d = reg_raddr_q;
    reg_we_d    = 1'b0;
    reg_waddr_d = reg_waddr_q;
    reg_d_d     = reg_d_q;
    mem_raddr_d = mem_raddr_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_d_d     = mem_d_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    i_we_d      = 1'b0;
    i_out_d     = i_out_q;

    vpipe_d[0] = iss_q;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
    end

    // Write side runs off the data-valid pipe so it can overlap the issue phase
    if (w_dv) begin
      wcnt_d = wcnt_q + CW'(1);
      if (mode_q == c_MODE_STORE) begin
        mem_we_d    = 1'b1;
        mem_waddr_d = base_q + ADDR_WIDTH'(wcnt_q);
        mem_d_d     = reg_q_i;
      end else begin
        reg_we_d    = 1'b1;
        reg_waddr_d = wcnt_q[REG_ADDR_WIDTH-1:0];
        reg_d_d     = mem_q_i;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_i && (mode_i != c_MODE_ILL)) begin
          busy_d = 1'b1;
          mode_d = mode_i;
          base_d = i_in_i;
          last_d = x_i;
          rcnt_d = '0;
          wcnt_d = '0;
          iss_d  = (mode_i != c_MODE_BCD);
          if (mode_i == c_MODE_LOAD) begin
            mem_raddr_d = i_in_i;
            state_d     = S_RD_MEM;
          end else begin
            reg_raddr_d = (mode_i == c_MODE_BCD) ? x_i : '0;
            state_d     = S_RD_REG;
          end
        end
      end
      S_RD_REG, S_RD_MEM: begin
        if (mode_q == c_MODE_BCD || rcnt_q == last_q) begin
          iss_d   = 1'b0;
          state_d = S_STREAM;
        end else begin
          rcnt_d = w_rnext;
          if (state_q == S_RD_REG) begin
            reg_raddr_d = w_rnext;
          end else begin
            mem_raddr_d = base_q + ADDR_WIDTH'(w_rnext);
          end
        end
      end
      S_STREAM: begin
        if (mode_q == c_MODE_BCD) begin
          bin_d   = reg_q_i;
          bcd_d   = '0;
          bcnt_d  = '0;
          state_d = S_BCD_CONV;
        end else if (wcnt_q == w_total) begin
          done_d  = 1'b1;
          state_d = S_DONE;
          if (INC_I) begin
            i_we_d  = 1'b1;
            i_out_d = base_q + ADDR_WIDTH'(w_total);
          end
        end
      end
      S_BCD_CONV: begin
        bin_d  = w_bin_n;
        bcd_d  = w_bcd_n;
        bcnt_d = bcnt_q + 3'd1;
        // Last shift: the hundreds digit goes straight out so writes start next cycle
        if (bcnt_q == 3'd7) begin
          mem_we_d    = 1'b1;
          mem_waddr_d = base_q;
          mem_d_d     = DATA_WIDTH'(w_bcd_n[11:8]);
          bcnt_d      = '0;
          state_d     = S_BCD_WR;
        end
      end
      S_BCD_WR: begin
        bcnt_d = bcnt_q + 3'd1;
        case (bcnt_q)
          3'd0: begin
            mem_we_d    = 1'b1;
            mem_waddr_d = base_q + ADDR_WIDTH'(1);
            mem_d_d     = DATA_WIDTH'(bcd_q[7:4]);
          end
          3'd1: begin
            mem_we_d    = 1'b1;
            mem_waddr_d = base_q + ADDR_WIDTH'(2);
            mem_d_d     = DATA_WIDTH'(bcd_q[3:0]);
          end
          default: begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        endcase
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= c_MODE_STORE;
      base_q      <= '0;
      last_q      <= '0;
      rcnt_q      <= '0;
      wcnt_q      <= '0;
      iss_q       <= 1'b0;
      vpipe_q     <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      bcnt_q      <= '0;
      reg_raddr_q <= '0;
      reg_we_q    <= 1'b0;
      reg_waddr_q <= '0;
      reg_d_q     <= '0;
      mem_raddr_q <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_d_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      i_we_q      <= 1'b0;
      i_out_q     <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      base_q      <= base_d;
      last_q      <= last_d;
      rcnt_q      <= rcnt_d;
      wcnt_q      <= wcnt_d;
      iss_q       <= iss_d;
      vpipe_q     <= vpipe_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      bcnt_q      <= bcnt_d;
      reg_raddr_q <= reg_raddr_d;
      reg_we_q    <= reg_we_d;
      reg_waddr_q <= reg_waddr_d;
      reg_d_q     <= reg_d_d;
      mem_raddr_q <= mem_raddr_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_d_q     <= mem_d_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      i_we_q      <= i_we_d;
      i_out_q     <= i_out_d;
    end
  end

  assign reg_raddr_o = reg_raddr_q;
  assign reg_we_o    = reg_we_q;
  assign reg_waddr_o = reg_waddr_q;
  assign reg_d_o     = reg_d_q;
  assign mem_raddr_o = mem_raddr_q;
  assign mem_we_o    = mem_we_q;
  assign mem_waddr_o = mem_waddr_q;
  assign mem_d_o     = mem_d_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign i_we_o      = i_we_q;
  assign i_out_o     = i_out_q;

endmodule
`default_nettype wire

// File: tb/tb_chip8_xfer_engine.sv
`default_nettype none
// ============================================================================
// tb_chip8_xfer_engine : directed vector bench, V-RAM and main memory models
// Revision 1.0
// ============================================================================
module tb_chip8_xfer_engine;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [3:0]  x = 4'd0;
  logic [11:0] i_in = 12'h000;
  logic [3:0]  reg_raddr, reg_waddr;
  logic [7:0]  reg_q, reg_d, mem_q, mem_d, mq1;
  logic        reg_we, mem_we, busy, done, i_we;
  logic [11:0] mem_raddr, mem_waddr, i_out;

  chip8_xfer_engine #(
    .ADDR_WIDTH(12), .DATA_WIDTH(8), .REG_ADDR_WIDTH(4), .MEM_LATENCY(LAT), .INC_I(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start), .mode_i(mode), .x_i(x), .i_in_i(i_in),
    .reg_raddr_o(reg_raddr), .reg_q_i(reg_q), .reg_we_o(reg_we), .reg_waddr_o(reg_waddr),
    .reg_d_o(reg_d), .mem_raddr_o(mem_raddr), .mem_q_i(mem_q), .mem_we_o(mem_we),
    .mem_waddr_o(mem_waddr), .mem_d_o(mem_d), .busy_o(busy), .done_o(done),
    .i_we_o(i_we), .i_out_o(i_out)
  );

  always #5 clk = ~clk;

  logic [7:0]  vram [16];
  logic [7:0]  mem  [4096];
  logic        tb_vwe = 1'b0, tb_mwe = 1'b0;
  logic [3:0]  tb_va = 4'd0;
  logic [11:0] tb_ma = 12'd0;
  logic [7:0]  tb_d = 8'd0;

  always @(posedge clk) begin
    reg_q <= vram[reg_raddr];
    mq1   <= mem[mem_raddr];
    mem_q <= mq1;
    if (reg_we) vram[reg_waddr] <= reg_d;
    if (mem_we) mem[mem_waddr] <= mem_d;
    if (tb_vwe) vram[tb_va] <= tb_d;
    if (tb_mwe) mem[tb_ma] <= tb_d;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] vpat(input int k);
    return 8'((k + 1) * 17);
  endfunction

  function automatic logic [7:0] mpat(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], 4'h3};
  endfunction

  task automatic setv(input logic [3:0] a, input logic [7:0] d);
    tb_vwe = 1'b1; tb_va = a; tb_d = d;
    tick();
    tb_vwe = 1'b0;
  endtask

  task automatic setm(input logic [11:0] a, input logic [7:0] d);
    tb_mwe = 1'b1; tb_ma = a; tb_d = d;
    tick();
    tb_mwe = 1'b0;
  endtask

  int          wc[$], wa[$], wd[$];
  int          done_cyc, n_done;
  logic        iwe_at_done, overlap, busy_gap, extra_wr;
  logic [11:0] iout_at_done;

  task automatic run_cmd(input logic [1:0] m, input logic [3:0] xx, input logic [11:0] ii,
                         input int budget);
    wc.delete(); wa.delete(); wd.delete();
    done_cyc = -1; n_done = 0; iwe_at_done = 1'b0; iout_at_done = 12'h000;
    overlap = 1'b0; busy_gap = 1'b0; extra_wr = 1'b0;
    mode = m; x = xx; i_in = ii; start = 1'b1;
    tick();
    start = 1'b0;
    i_in = ~ii;
    for (int c = 1; c <= budget; c++) begin
      if (reg_we && mem_we) overlap = 1'b1;
      if (!busy) busy_gap = 1'b1;
      if (mem_we) begin wc.push_back(c); wa.push_back(int'(mem_waddr)); wd.push_back(int'(mem_d)); end
      if (reg_we) begin wc.push_back(c); wa.push_back(int'(reg_waddr)); wd.push_back(int'(reg_d)); end
      if (done) begin
        n_done++; done_cyc = c; iwe_at_done = i_we; iout_at_done = i_out;
        break;
      end
      tick();
    end
    repeat (3) begin
      tick();
      if (done) n_done++;
      if (reg_we || mem_we || busy) extra_wr = 1'b1;
    end
  endtask

  typedef struct {
    logic [1:0]  m;
    logic [3:0]  x;
    logic [11:0] i;
    logic [7:0]  v;
    int          first;
    int          nwr;
    int          dn;
    logic        iwe;
    logic [11:0] iout;
    logic [11:0] bcd;
  } vec_t;

  vec_t vt [11];

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] a;
    logic [7:0]  ed;
    int          ea, nd, nw, dc, rc;
    logic        bad;

    vt[0]  = '{2'd0, 4'd3,  12'h300, 8'h00, 3,  4,  7,  1'b1, 12'h304, 12'h000};
    vt[1]  = '{2'd1, 4'd15, 12'hFFE, 8'h00, 4,  16, 20, 1'b1, 12'h00E, 12'h000};
    vt[2]  = '{2'd2, 4'd5,  12'h400, 8'hFE, 11, 3,  14, 1'b0, 12'h000, 12'h254};
    vt[3]  = '{2'd2, 4'd5,  12'h400, 8'h00, 11, 3,  14, 1'b0, 12'h000, 12'h000};
    vt[4]  = '{2'd2, 4'd5,  12'h400, 8'h09, 11, 3,  14, 1'b0, 12'h000, 12'h009};
    vt[5]  = '{2'd2, 4'd9,  12'hFFE, 8'h64, 11, 3,  14, 1'b0, 12'h000, 12'h100};
    vt[6]  = '{2'd0, 4'd2,  12'h200, 8'h00, 3,  3,  6,  1'b1, 12'h203, 12'h000};
    vt[7]  = '{2'd0, 4'd0,  12'hFFF, 8'h00, 3,  1,  4,  1'b1, 12'h000, 12'h000};
    vt[8]  = '{2'd0, 4'd15, 12'hFF8, 8'h00, 3,  16, 19, 1'b1, 12'h008, 12'h000};
    vt[9]  = '{2'd1, 4'd0,  12'h123, 8'h00, 4,  1,  5,  1'b1, 12'h124, 12'h000};
    vt[10] = '{2'd1, 4'd3,  12'h7FE, 8'h00, 4,  4,  8,  1'b1, 12'h802, 12'h000};

    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_strobes", {reg_we, mem_we, i_we}, 0);
    chk("rst_addrs", {reg_raddr, reg_waddr, mem_raddr, mem_waddr}, 0);
    chk("rst_data_iout", {reg_d, mem_d, i_out}, 0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 11; v++) begin
      for (int k = 0; k < 16; k++) setv(4'(k), vpat(k));
      if (vt[v].m == 2'd2) setv(vt[v].x, vt[v].v);
      if (vt[v].m == 2'd1) begin
        for (int k = 0; k <= int'(vt[v].x); k++) begin
          a = vt[v].i + 12'(k);
          setm(a, mpat(a));
        end
      end
      run_cmd(vt[v].m, vt[v].x, vt[v].i, vt[v].dn + 10);
      chk($sformatf("v%0d_done_cycle", v), done_cyc, vt[v].dn);
      chk($sformatf("v%0d_write_count", v), wc.size(), vt[v].nwr);
      for (int k = 0; k < vt[v].nwr && k < wc.size(); k++) begin
        a = vt[v].i + 12'(k);
        if (vt[v].m == 2'd1) begin
          ea = k; ed = mpat(a);
        end else if (vt[v].m == 2'd0) begin
          ea = int'(a); ed = vpat(k);
        end else begin
          ea = int'(a); ed = 8'((vt[v].bcd >> (8 - 4 * k)) & 12'h00F);
        end
        chk($sformatf("v%0d_w%0d_cycle", v, k), wc[k], vt[v].first + k);
        chk($sformatf("v%0d_w%0d_addr", v, k), wa[k], ea);
        chk($sformatf("v%0d_w%0d_data", v, k), wd[k], ed);
      end
      chk($sformatf("v%0d_i_we", v), iwe_at_done, vt[v].iwe);
      if (vt[v].iwe) chk($sformatf("v%0d_i_out", v), iout_at_done, vt[v].iout);
      chk($sformatf("v%0d_single_done", v), n_done, 1);
      chk($sformatf("v%0d_we_overlap", v), overlap, 0);
      chk($sformatf("v%0d_busy_window", v), busy_gap, 0);
      chk($sformatf("v%0d_quiet_after", v), extra_wr, 0);
    end

    // illegal mode is ignored
    bad = 1'b0;
    mode = 2'b11; x = 4'd2; i_in = 12'h100; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) begin
      if (busy || done || reg_we || mem_we || i_we) bad = 1'b1;
      tick();
    end
    chk("illegal_mode_ignored", bad, 0);

    // start held high through a LOAD x=4
    for (int k = 0; k < 5; k++) setm(12'h050 + 12'(k), mpat(12'h050 + 12'(k)));
    mode = 2'b01; x = 4'd4; i_in = 12'h050; start = 1'b1;
    tick();
    nd = 0; nw = 0; dc = -1;
    for (int c = 1; c <= 40; c++) begin
      if (reg_we) nw++;
      if (done) begin
        nd++;
        if (dc < 0) dc = c;
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk("hold_done_count", nd, 1);
    chk("hold_reg_we_count", nw, 5);
    chk("hold_done_cycle", dc, 9);
    chk("hold_busy_after", busy, 0);

    // reset after the second reg_we of LOAD x=7
    for (int k = 0; k < 8; k++) setm(12'h010 + 12'(k), mpat(12'h010 + 12'(k)));
    mode = 2'b01; x = 4'd7; i_in = 12'h010; start = 1'b1;
    tick();
    start = 1'b0;
    nw = 0; rc = -1;
    for (int c = 1; c <= 30; c++) begin
      if (reg_we) begin
        nw++;
        if (nw == 2) begin
          rc = c;
          rst = 1'b1;
          tick();
          break;
        end
      end
      tick();
    end
    chk("midrst_second_we_cycle", rc, 5);
    chk("midrst_busy", busy, 0);
    chk("midrst_strobes", {reg_we, mem_we, done, i_we}, 0);
    rst = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      tick();
      if (busy || done || reg_we || mem_we) bad = 1'b1;
    end
    chk("midrst_quiet", bad, 0);

    // reset and start together
    rst = 1'b1; start = 1'b1; mode = 2'b00; x = 4'd2; i_in = 12'h222;
    tick();
    rst = 1'b0; start = 1'b0;
    bad = 1'b0;
    repeat (15) begin
      if (busy || done || reg_we || mem_we) bad = 1'b1;
      tick();
    end
    chk("rst_start_same_cycle", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
